// File: rtl/cpu_pkg.sv
// cpu_pkg: shared RAM widths and RAM arbiter state encoding
package cpu_pkg;
  localparam int CPU_ADDR_W = 8;
  localparam int CPU_DATA_W = 8;
  typedef enum logic [1:0] {CPU_OWN, DRAIN, HOST, GAP} arb_state_t;
endpackage

// File: rtl/ram_port_mux.sv
// ram_port_mux: selects CPU or host signals onto the single RAM port
module ram_port_mux
  import cpu_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DATA_W = CPU_DATA_W
) (
  input  logic              host_sel,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_rden,
  input  logic              cpu_wren,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_rden,
  output logic              ram_wren
);
  // host strobes only pass when a request is present; write wins so the port never sees both
  always_comb begin
    ram_addr    = host_sel ? host_addr : cpu_addr;
    ram_data_in = host_sel ? host_wdata : cpu_wdata;
    ram_wren    = host_sel ? host_req & host_we : cpu_wren;
    ram_rden    = host_sel ? host_req & ~host_we : cpu_rden & ~cpu_wren;
  end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the program/data RAM between the CPU and a host port in bounded bursts
module ram_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = CPU_ADDR_W,
  parameter int DATA_W     = CPU_DATA_W,
  parameter int MAX_BURST  = 16,
  parameter int GAP_CYCLES = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_rden,
  input  logic              cpu_wren,
  input  logic              cpu_idle,
  output logic              cpu_hold,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_rden,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              conflict
);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);
  arb_state_t r_state, w_next;
  logic [BW-1:0] r_burst, w_burst_next;
  logic [GW-1:0] r_gap, w_gap_next;
  logic r_rvalid, r_conflict;
  logic w_host_sel, w_grant;
  assign w_host_sel  = r_state == HOST;
  assign w_grant     = w_host_sel & host_req;
  assign host_gnt    = w_grant;
  assign host_rvalid = r_rvalid;
  assign host_rdata  = ram_q;
  assign conflict    = r_conflict;
  assign cpu_hold    = (r_state == DRAIN) | w_host_sel | ((r_state == CPU_OWN) & host_req);
  ram_port_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
    .host_sel   (w_host_sel),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rden   (cpu_rden),
    .cpu_wren   (cpu_wren),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .ram_addr   (ram_addr),
    .ram_data_in(ram_data_in),
    .ram_rden   (ram_rden),
    .ram_wren   (ram_wren)
  );
  // ownership sequencing: the terminal burst count forces the CPU gap
  always_comb begin
    w_next       = r_state;
    w_burst_next = r_burst;
    w_gap_next   = r_gap;
    case (r_state)
      CPU_OWN: w_next = host_req ? DRAIN : CPU_OWN;
      DRAIN:   w_next = cpu_idle ? HOST : DRAIN;
      HOST: begin
        if (!host_req) begin
          w_next       = CPU_OWN;
          w_burst_next = '0;
        end else if (r_burst == BURST_LAST) begin
          w_next       = GAP;
          w_burst_next = '0;
          w_gap_next   = GAP_LOAD;
        end else begin
          w_burst_next = r_burst + 1'b1;
        end
      end
      GAP: begin
        w_gap_next = r_gap - 1'b1;
        w_next     = (r_gap == GW'(1)) ? CPU_OWN : GAP;
      end
      default: w_next = CPU_OWN;
    endcase
  end
  // state, counters, read-valid pipeline and sticky conflict flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= CPU_OWN;
      r_burst    <= '0;
      r_gap      <= '0;
      r_rvalid   <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_burst    <= w_burst_next;
      r_gap      <= w_gap_next;
      r_rvalid   <= w_grant & ~host_we;
      r_conflict <= r_conflict | (w_host_sel & (cpu_rden | cpu_wren));
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard-checked bench for ram_arbiter with a behavioural RAM
module tb_ram_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] cpu_addr = '0, cpu_wdata = '0, host_addr = '0, host_wdata = '0;
  logic       cpu_rden = 1'b0, cpu_wren = 1'b0, cpu_idle = 1'b1;
  logic       host_req = 1'b0, host_we = 1'b0;
  logic       cpu_hold, host_gnt, host_rvalid, ram_rden, ram_wren, conflict;
  logic [7:0] host_rdata, ram_addr, ram_data_in;
  logic [7:0] ram_q = '0;
  logic [7:0] mem [256];
  logic [7:0] shadow [256];
  logic [7:0] exp_q [$];
  int errors = 0;
  int checks = 0;
  int grants;
  ram_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rden(cpu_rden), .cpu_wren(cpu_wren),
    .cpu_idle(cpu_idle), .cpu_hold(cpu_hold),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_rden(ram_rden), .ram_wren(ram_wren),
    .ram_q(ram_q), .conflict(conflict)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic nxt();
    @(posedge clk);
    #2;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      shadow[i] = '0;
    end
  end
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_data_in;
    if (ram_rden) ram_q <= mem[ram_addr];
  end
  always @(negedge clk) begin
    check("excl", {31'd0, ram_rden & ram_wren}, 0);
    if (host_rvalid) begin
      if (exp_q.size() == 0) check("sb_under", 1, 0);
      else check("sb_rdata", host_rdata, exp_q.pop_front());
    end
    if (host_gnt && host_we) shadow[host_addr] = host_wdata;
    if (host_gnt && !host_we && !rst) exp_q.push_back(shadow[host_addr]);
  end
  initial begin
    cpu_rden = 1'b1;
    cpu_addr = 8'h12;
    nxt();
    nxt();
    rst = 1'b0;
    #1;
    check("rst_addr", ram_addr, 8'h12);
    check("rst_rden", ram_rden, 1);
    check("rst_hold", cpu_hold, 0);
    check("rst_gnt", host_gnt, 0);
    check("rst_rvalid", host_rvalid, 0);
    check("rst_conflict", conflict, 0);
    nxt();
    cpu_rden = 1'b0;
    cpu_idle = 1'b0;
    host_req = 1'b1;
    host_we = 1'b1;
    host_addr = 8'h40;
    host_wdata = 8'hA5;
    #1;
    check("own_hold", cpu_hold, 1);
    check("own_gnt", host_gnt, 0);
    for (int i = 0; i < 2; i++) begin
      nxt();
      #1;
      check("drain_hold", cpu_hold, 1);
      check("drain_gnt", host_gnt, 0);
    end
    nxt();
    cpu_idle = 1'b1;
    #1;
    check("idle_gnt", host_gnt, 0);
    nxt();
    #1;
    check("wr_gnt", host_gnt, 1);
    check("wr_wren", ram_wren, 1);
    check("wr_addr", ram_addr, 8'h40);
    check("wr_data", ram_data_in, 8'hA5);
    nxt();
    host_req = 1'b0;
    #1;
    check("host_idle_gnt", host_gnt, 0);
    check("host_idle_hold", cpu_hold, 1);
    check("host_idle_wren", ram_wren, 0);
    nxt();
    cpu_rden = 1'b1;
    cpu_addr = 8'h40;
    #1;
    check("back_hold", cpu_hold, 0);
    nxt();
    cpu_rden = 1'b0;
    check("cpu_rd_40", ram_q, 8'hA5);
    host_req = 1'b1;
    host_we = 1'b0;
    nxt();
    nxt();
    #1;
    check("rd_gnt", host_gnt, 1);
    check("rd_rden", ram_rden, 1);
    check("rd_rvalid_k", host_rvalid, 0);
    nxt();
    host_req = 1'b0;
    #1;
    check("rd_rvalid_k1", host_rvalid, 1);
    check("rd_rdata", host_rdata, 8'hA5);
    nxt();
    #1;
    check("rd_rvalid_k2", host_rvalid, 0);
    grants = 0;
    host_req = 1'b1;
    host_we = 1'b1;
    for (int c = 0; c < 26; c++) begin
      if (c > 0) nxt();
      host_addr = 8'(8'h80 + c);
      host_wdata = 8'(c);
      #1;
      check($sformatf("burst_gnt_%0d", c), host_gnt, ((c >= 2 && c <= 17) || c == 25) ? 1 : 0);
      check($sformatf("burst_hold_%0d", c), cpu_hold, (c >= 18 && c <= 22) ? 0 : 1);
      if (c <= 24 && host_gnt) grants++;
    end
    check("burst_count", grants, 16);
    nxt();
    host_req = 1'b0;
    nxt();
    cpu_rden = 1'b1;
    cpu_addr = 8'h91;
    nxt();
    check("burst_last", ram_q, 8'd17);
    cpu_addr = 8'h92;
    nxt();
    check("burst_after", ram_q, 8'd0);
    cpu_addr = 8'h81;
    nxt();
    check("burst_drain_addr", ram_q, 8'd0);
    cpu_addr = 8'h82;
    nxt();
    check("burst_first", ram_q, 8'd2);
    cpu_rden = 1'b0;
    host_req = 1'b1;
    host_we = 1'b1;
    host_addr = 8'h50;
    host_wdata = 8'h3C;
    nxt();
    nxt();
    cpu_wren = 1'b1;
    cpu_addr = 8'h60;
    cpu_wdata = 8'hEE;
    #1;
    check("cf_addr", ram_addr, 8'h50);
    check("cf_wren", ram_wren, 1);
    nxt();
    cpu_wren = 1'b0;
    host_req = 1'b0;
    #1;
    check("cf_set", conflict, 1);
    nxt();
    nxt();
    cpu_rden = 1'b1;
    #1;
    check("cf_sticky", conflict, 1);
    nxt();
    check("cf_no_write", ram_q, 8'h00);
    cpu_addr = 8'h50;
    nxt();
    check("cf_host_write", ram_q, 8'h3C);
    cpu_rden = 1'b0;
    host_req = 1'b1;
    host_we = 1'b0;
    host_addr = 8'h40;
    nxt();
    nxt();
    rst = 1'b1;
    #1;
    check("rr_gnt", host_gnt, 1);
    nxt();
    rst = 1'b0;
    host_req = 1'b0;
    cpu_rden = 1'b1;
    cpu_addr = 8'h33;
    #1;
    check("rr_rvalid", host_rvalid, 0);
    check("rr_hold", cpu_hold, 0);
    check("rr_gnt_off", host_gnt, 0);
    check("rr_addr", ram_addr, 8'h33);
    check("rr_rden", ram_rden, 1);
    check("rr_conflict", conflict, 0);
    nxt();
    nxt();
    check("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
